// File: rtl/traffic_phase_scheduler_pkg.sv
// Shared state codes, light codes and default
// phase durations for the intersection scheduler.
package traffic_phase_scheduler_pkg;

  typedef enum logic [2:0] {
    ST_INIT   = 3'd0,
    ST_A_GRN  = 3'd1,
    ST_A_YEL  = 3'd2,
    ST_ARED_B = 3'd3,
    ST_B_GRN  = 3'd4,
    ST_B_YEL  = 3'd5,
    ST_ARED_A = 3'd6
  } state_e;

  localparam logic [1:0] LT_RED = 2'b00;
  localparam logic [1:0] LT_YEL = 2'b01;
  localparam logic [1:0] LT_GRN = 2'b10;

  localparam logic [7:0] DEF_GREEN_T  = 8'h30;
  localparam logic [7:0] DEF_YELLOW_T = 8'h05;
  localparam logic [7:0] DEF_ALLRED_T = 8'h02;
  localparam logic [3:0] DEF_GAP_CYC  = 4'd8;

  // {A_Light, B_Light} shown while in state s
  function automatic logic [3:0] lights_of(
    input state_e s
  );
    case (s)
      ST_A_GRN: lights_of = {LT_GRN, LT_RED};
      ST_A_YEL: lights_of = {LT_YEL, LT_RED};
      ST_B_GRN: lights_of = {LT_RED, LT_GRN};
      ST_B_YEL: lights_of = {LT_RED, LT_YEL};
      default:  lights_of = {LT_RED, LT_RED};
    endcase
  endfunction

endpackage

// File: rtl/tsched_gap_timer.sv
// Saturating gap-out cycle counter; hit while
// the count sits at LIMIT.
module tsched_gap_timer
  import traffic_phase_scheduler_pkg::*;
#(
  parameter logic [3:0] LIMIT = DEF_GAP_CYC
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_clr,
  input  logic i_inc,
  output logic o_hit
);

  logic [3:0] r_cnt;

  // Clear has priority; count up until LIMIT
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt <= 4'd0;
    end else if (i_clr) begin
      r_cnt <= 4'd0;
    end else if (i_inc && (r_cnt < LIMIT)) begin
      r_cnt <= r_cnt + 4'd1;
    end
  end

  assign o_hit = (r_cnt == LIMIT);

endmodule

// File: rtl/traffic_phase_scheduler.sv
// Two-road phase sequencer driving the BCD counter pair.
// Option: TSCHED_EXTEND_EN enables up to 2 green extensions.
module traffic_phase_scheduler
  import traffic_phase_scheduler_pkg::*;
#(
  parameter logic [7:0] GREEN_T  = DEF_GREEN_T,
  parameter logic [7:0] YELLOW_T = DEF_YELLOW_T,
  parameter logic [7:0] ALLRED_T = DEF_ALLRED_T,
  parameter logic [3:0] GAP_CYC  = DEF_GAP_CYC
) (
  input  logic       CLK,
  input  logic       R,
  input  logic       A_Traffic,
  input  logic       B_Traffic,
  input  logic       MAN,
  input  logic       MAN_A,
  input  logic       cnt_zero,
  output logic       ld,
  output logic [3:0] ld_msb,
  output logic [3:0] ld_lsb,
  output logic [1:0] A_Light,
  output logic [1:0] B_Light,
  output logic [2:0] phase
);

  state_e     r_state;
  logic       r_ld;
  logic [7:0] r_ld_val;
  logic [3:0] r_lt;
  logic       r_armed;
  logic       r_man_q;

  state_e     w_nx;
  state_e     w_yel;
  logic       w_on_a;
  logic       w_green;
  logic       w_own;
  logic       w_oth;
  logic       w_sel_own;
  logic       w_tmo;
  logic       w_man_fall;
  logic       w_ext_ok;
  logic       w_reload;
  logic       w_chg;
  logic       w_ld;
  logic [7:0] w_dur;
  logic       w_gap_inc;
  logic       w_gap_clr;
  logic       w_gap_hit;

`ifdef TSCHED_EXTEND_EN
  logic [1:0] r_ext;

  // Extensions granted in the current green
  always_ff @(posedge CLK or negedge R) begin
    if (!R) begin
      r_ext <= 2'd0;
    end else if (w_chg) begin
      r_ext <= 2'd0;
    end else if (w_reload && !w_man_fall) begin
      r_ext <= r_ext + 2'd1;
    end
  end
`endif

  // Next phase, load request and load value
  always_comb begin
    w_on_a     = (r_state == ST_A_GRN);
    w_green    = w_on_a || (r_state == ST_B_GRN);
    w_own      = w_on_a ? A_Traffic : B_Traffic;
    w_oth      = w_on_a ? B_Traffic : A_Traffic;
    w_sel_own  = w_on_a ? MAN_A : ~MAN_A;
    w_tmo      = r_armed & cnt_zero;
    w_man_fall = r_man_q & ~MAN;
    w_yel      = ST_B_YEL;
    if (w_on_a) w_yel = ST_A_YEL;
`ifdef TSCHED_EXTEND_EN
    w_ext_ok = w_own & ~w_oth & (r_ext != 2'd2);
`else
    w_ext_ok = 1'b0;
`endif
    w_nx     = r_state;
    w_reload = 1'b0;
    unique case (r_state)
      ST_INIT: w_nx = ST_A_GRN;
      ST_A_GRN, ST_B_GRN: begin
        if (MAN) begin
          if (!w_sel_own) w_nx = w_yel;
        end else if (w_man_fall) begin
          w_reload = 1'b1;
        end else if (w_tmo) begin
          if (w_ext_ok) w_reload = 1'b1;
          else          w_nx = w_yel;
        end else if (w_gap_hit) begin
          w_nx = w_yel;
        end
      end
      ST_A_YEL: if (w_tmo) w_nx = ST_ARED_B;
      ST_B_YEL: if (w_tmo) w_nx = ST_ARED_A;
      ST_ARED_B: begin
        if (w_tmo) begin
          if (MAN && MAN_A) w_nx = ST_A_GRN;
          else              w_nx = ST_B_GRN;
        end
      end
      ST_ARED_A: begin
        if (w_tmo) begin
          if (MAN && !MAN_A) w_nx = ST_B_GRN;
          else               w_nx = ST_A_GRN;
        end
      end
      default: w_nx = ST_ARED_A;
    endcase
    w_chg = (w_nx != r_state);
    w_ld  = w_chg | w_reload;
    case (w_nx)
      ST_A_GRN, ST_B_GRN: w_dur = GREEN_T;
      ST_A_YEL, ST_B_YEL: w_dur = YELLOW_T;
      default:            w_dur = ALLRED_T;
    endcase
    w_gap_inc = w_green & ~w_own & w_oth;
    w_gap_clr = ~w_gap_inc | w_ld;
  end

  tsched_gap_timer #(
    .LIMIT (GAP_CYC)
  ) u_gap (
    .i_clk   (CLK),
    .i_rst_n (R),
    .i_clr   (w_gap_clr),
    .i_inc   (w_gap_inc),
    .o_hit   (w_gap_hit)
  );

  // Phase state register
  always_ff @(posedge CLK or negedge R) begin
    if (!R) r_state <= ST_INIT;
    else    r_state <= w_nx;
  end

  // Registered outputs, arming and MAN history
  always_ff @(posedge CLK or negedge R) begin
    if (!R) begin
      r_ld     <= 1'b0;
      r_ld_val <= 8'h00;
      r_lt     <= {LT_RED, LT_RED};
      r_armed  <= 1'b0;
      r_man_q  <= 1'b0;
    end else begin
      r_ld    <= w_ld;
      if (w_ld) r_ld_val <= w_dur;
      r_lt    <= lights_of(w_nx);
      r_armed <= ~w_ld;
      r_man_q <= MAN;
    end
  end

  assign ld      = r_ld;
  assign ld_msb  = r_ld_val[7:4];
  assign ld_lsb  = r_ld_val[3:0];
  assign A_Light = r_lt[3:2];
  assign B_Light = r_lt[1:0];
  assign phase   = r_state;

endmodule

// File: tb/tb_traffic_phase_scheduler.sv
// Self-checking bench for traffic_phase_scheduler.
// Table-driven cycle plus hand-written corner sequences.
module tb_traffic_phase_scheduler;

  logic       CLK = 1'b0;
  logic       R = 1'b0;
  logic       A_Traffic = 1'b0;
  logic       B_Traffic = 1'b0;
  logic       MAN = 1'b0;
  logic       MAN_A = 1'b0;
  logic       cnt_zero = 1'b0;
  logic       ld;
  logic [3:0] ld_msb;
  logic [3:0] ld_lsb;
  logic [1:0] A_Light;
  logic [1:0] B_Light;
  logic [2:0] phase;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic [2:0] ph;
    logic       l;
    logic [7:0] v;
  } exp_t;

  typedef struct {
    logic       a;
    logic       b;
    logic       m;
    logic       ma;
    logic       cz;
    logic [2:0] ph;
    logic       l;
    logic [7:0] v;
  } vec_t;

  exp_t sb[$];
  vec_t vt[15];

  always #5 CLK = ~CLK;

  traffic_phase_scheduler dut (
    .CLK       (CLK),
    .R         (R),
    .A_Traffic (A_Traffic),
    .B_Traffic (B_Traffic),
    .MAN       (MAN),
    .MAN_A     (MAN_A),
    .cnt_zero  (cnt_zero),
    .ld        (ld),
    .ld_msb    (ld_msb),
    .ld_lsb    (ld_lsb),
    .A_Light   (A_Light),
    .B_Light   (B_Light),
    .phase     (phase)
  );

  function automatic logic [3:0] lt_model(
    input logic [2:0] ph
  );
    case (ph)
      3'd1:    lt_model = 4'b1000;
      3'd2:    lt_model = 4'b0100;
      3'd4:    lt_model = 4'b0010;
      3'd5:    lt_model = 4'b0001;
      default: lt_model = 4'b0000;
    endcase
  endfunction

  task automatic cmp(
    input string nm,
    input int    got,
    input int    want
  );
    n_tests++;
    if (got != want) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h",
               nm, got, want);
    end
  endtask

  task automatic chk(input string nm);
    exp_t e;
    if (sb.size() == 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL %s: scoreboard empty", nm);
      return;
    end
    e = sb.pop_front();
    cmp({nm, " phase"}, int'(phase), int'(e.ph));
    cmp({nm, " ld"}, int'(ld), int'(e.l));
    if (e.l)
      cmp({nm, " ldval"}, int'({ld_msb, ld_lsb}),
          int'(e.v));
    cmp({nm, " lights"}, int'({A_Light, B_Light}),
        int'(lt_model(e.ph)));
    n_tests++;
    if (A_Light != 2'b00 && B_Light != 2'b00) begin
      n_fail++;
      $display("FAIL %s both_lit: got %b/%b want one red",
               nm, A_Light, B_Light);
    end
  endtask

  task automatic cyc(
    input logic       a,
    input logic       b,
    input logic       m,
    input logic       ma,
    input logic       cz,
    input logic [2:0] ph,
    input logic       l,
    input logic [7:0] v,
    input string      nm
  );
    exp_t e;
    @(negedge CLK);
    A_Traffic = a;
    B_Traffic = b;
    MAN       = m;
    MAN_A     = ma;
    cnt_zero  = cz;
    e.ph = ph;
    e.l  = l;
    e.v  = v;
    sb.push_back(e);
    @(posedge CLK);
    #1;
    chk(nm);
  endtask

  initial begin
    vt[0]  = '{1'b0,1'b0,1'b0,1'b0,1'b0,3'd1,1'b1,8'h30};
    vt[1]  = '{1'b0,1'b0,1'b0,1'b0,1'b1,3'd1,1'b0,8'h00};
    vt[2]  = '{1'b0,1'b0,1'b0,1'b0,1'b0,3'd1,1'b0,8'h00};
    vt[3]  = '{1'b0,1'b0,1'b0,1'b0,1'b1,3'd2,1'b1,8'h05};
    vt[4]  = '{1'b0,1'b0,1'b0,1'b0,1'b1,3'd2,1'b0,8'h00};
    vt[5]  = '{1'b0,1'b0,1'b0,1'b0,1'b1,3'd3,1'b1,8'h02};
    vt[6]  = '{1'b0,1'b0,1'b0,1'b0,1'b0,3'd3,1'b0,8'h00};
    vt[7]  = '{1'b1,1'b1,1'b0,1'b0,1'b1,3'd4,1'b1,8'h30};
    vt[8]  = '{1'b1,1'b1,1'b0,1'b0,1'b0,3'd4,1'b0,8'h00};
    vt[9]  = '{1'b1,1'b1,1'b0,1'b0,1'b1,3'd5,1'b1,8'h05};
    vt[10] = '{1'b0,1'b0,1'b0,1'b0,1'b0,3'd5,1'b0,8'h00};
    vt[11] = '{1'b0,1'b0,1'b0,1'b0,1'b1,3'd6,1'b1,8'h02};
    vt[12] = '{1'b0,1'b0,1'b0,1'b0,1'b0,3'd6,1'b0,8'h00};
    vt[13] = '{1'b0,1'b0,1'b0,1'b0,1'b1,3'd1,1'b1,8'h30};
    vt[14] = '{1'b0,1'b0,1'b0,1'b0,1'b0,3'd1,1'b0,8'h00};

    // reset state
    repeat (2) @(posedge CLK);
    #1;
    cmp("rst phase", int'(phase), 0);
    cmp("rst ld", int'(ld), 0);
    cmp("rst ldval", int'({ld_msb, ld_lsb}), 0);
    cmp("rst lights", int'({A_Light, B_Light}), 0);
    #1 R = 1'b1;

    // full cycle
    for (int i = 0; i < 15; i++)
      cyc(vt[i].a, vt[i].b, vt[i].m, vt[i].ma, vt[i].cz,
          vt[i].ph, vt[i].l, vt[i].v,
          $sformatf("vec%0d", i));

    // gap-out after 8 qualifying cycles
    for (int k = 0; k < 8; k++)
      cyc(0, 1, 0, 0, 0, 3'd1, 0, 8'h00, "gap_hold");
    cyc(0, 1, 0, 0, 0, 3'd2, 1, 8'h05, "gap_out");

    // asynchronous reset mid-phase
    @(posedge CLK);
    #2 R = 1'b0;
    #1;
    cmp("mid_rst phase", int'(phase), 0);
    cmp("mid_rst ld", int'(ld), 0);
    cmp("mid_rst lights", int'({A_Light, B_Light}), 0);
    #1 R = 1'b1;
    cyc(0, 0, 0, 0, 0, 3'd1, 1, 8'h30, "rst_rel");

    // broken gap does not hand over
    for (int k = 0; k < 4; k++)
      cyc(0, 1, 0, 0, 0, 3'd1, 0, 8'h00, "gap_pre");
    cyc(1, 1, 0, 0, 0, 3'd1, 0, 8'h00, "gap_break");
    for (int k = 0; k < 7; k++)
      cyc(0, 1, 0, 0, 0, 3'd1, 0, 8'h00, "gap_post");
    cyc(0, 0, 0, 0, 0, 3'd1, 0, 8'h00, "gap_none");

    // manual to B from A green
    cyc(0, 0, 1, 0, 0, 3'd2, 1, 8'h05, "man_yel");
    cyc(0, 0, 1, 0, 0, 3'd2, 0, 8'h00, "man_yel2");
    cyc(0, 0, 1, 0, 1, 3'd3, 1, 8'h02, "man_ared");
    cyc(0, 0, 1, 0, 0, 3'd3, 0, 8'h00, "man_ared2");
    cyc(0, 0, 1, 0, 1, 3'd4, 1, 8'h30, "man_bgrn");
    for (int k = 0; k < 100; k++)
      cyc(1, 0, 1, 0, 1, 3'd4, 0, 8'h00, "man_hold");
    cyc(0, 0, 0, 0, 0, 3'd4, 1, 8'h30, "man_drop");
    cyc(0, 0, 0, 0, 0, 3'd4, 0, 8'h00, "man_resume");

    // MAN rise with timeout in B green
    cyc(0, 0, 1, 1, 1, 3'd5, 1, 8'h05, "same_cyc");
    cyc(0, 0, 1, 1, 0, 3'd5, 0, 8'h00, "single_ld");
    cyc(0, 0, 1, 1, 1, 3'd6, 1, 8'h02, "man_ared_a");
    cyc(0, 0, 1, 1, 0, 3'd6, 0, 8'h00, "man_ared_a2");
    cyc(0, 0, 1, 1, 1, 3'd1, 1, 8'h30, "man_agrn");
    for (int k = 0; k < 3; k++)
      cyc(0, 1, 1, 1, 1, 3'd1, 0, 8'h00, "man_ahold");
    cyc(0, 0, 0, 0, 0, 3'd1, 1, 8'h30, "man_fall");
    cyc(1, 0, 0, 0, 0, 3'd1, 0, 8'h00, "auto_a");

`ifdef TSCHED_EXTEND_EN
    cyc(1, 0, 0, 0, 1, 3'd1, 1, 8'h30, "ext1");
    cyc(1, 0, 0, 0, 0, 3'd1, 0, 8'h00, "ext1_arm");
    cyc(1, 0, 0, 0, 1, 3'd1, 1, 8'h30, "ext2");
    cyc(1, 0, 0, 0, 0, 3'd1, 0, 8'h00, "ext2_arm");
    cyc(1, 0, 0, 0, 1, 3'd2, 1, 8'h05, "ext_end");
`else
    cyc(1, 0, 0, 0, 1, 3'd2, 1, 8'h05, "no_ext");
`endif

    cmp("sb_drained", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed",
             n_tests, n_fail);
    $finish;
  end

endmodule
